// File: rtl/sum_stream_fifo.sv
// First-word-fall-through FIFO that turns the upstream valid-only sum stream
// into a valid/ready stream, with fill level, sticky overflow and drop count.
module sum_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W:0]            dinp,
  input  logic                       valid_inp,
  output logic [DATA_W:0]            out,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            empty;
  logic            full;
  logic            do_read;
  logic            do_write;
  logic            drop;

  // Handshake: a word leaves the FIFO on any edge where valid_out && ready_out;
  // the input side has no ready, so a word arriving while full with no
  // concurrent read is dropped and counted.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    do_read  = !empty && ready_out;
    do_write = valid_inp && (!full || do_read);
    drop     = valid_inp && full && !do_read;
  end

  assign valid_out = !empty;
  assign out       = valid_out ? mem[rd_ptr[AW-1:0]] : '0;

  // Storage has no reset; only the pointers define which words are live.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      mem[wr_ptr[AW-1:0]] <= dinp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !do_read)      level <= level + 1'b1;
      else if (do_read && !do_write) level <= level - 1'b1;
    end
  end

  // A drop in the same cycle as ovf_clr restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_clr)        drop_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (!(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sum_stream_fifo.sv
// Bench for sum_stream_fifo: vector table, directed corner sequences and a
// randomized run, all checked against a queue-based model of the FIFO.
module tb_sum_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 4;
  localparam int DW     = DATA_W + 1;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dinp;
  logic          valid_inp;
  logic [DW-1:0] out;
  logic          valid_out;
  logic          ready_out;
  logic [LW-1:0] level;
  logic          ovf;
  logic          ovf_clr;
  logic [CNT_W-1:0] drop_cnt;

  sum_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .dinp(dinp), .valid_inp(valid_inp),
    .out(out), .valid_out(valid_out), .ready_out(ready_out),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the live contents in order, plus overflow bookkeeping.
  logic [DW-1:0] exp_q[$];
  logic          ovf_m;
  int            drop_m;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic [DW-1:0] e_out;
    logic          e_valid;
    logic [LW-1:0] e_level;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, then compare every output after the edge.
  task automatic cycle(input logic r_st, input logic v, input logic [DW-1:0] d,
                       input logic rd_en, input logic clr);
    logic rd, wr, drp;
    rst = r_st; valid_inp = v; dinp = d; ready_out = rd_en; ovf_clr = clr;
    if (r_st) begin
      exp_q.delete();
      ovf_m  = 1'b0;
      drop_m = 0;
    end else begin
      rd  = (exp_q.size() != 0) && rd_en;
      wr  = v && ((exp_q.size() < DEPTH) || rd);
      drp = v && !wr;
      if (rd) void'(exp_q.pop_front());
      if (wr) exp_q.push_back(d);
      if (drp) begin
        ovf_m  = 1'b1;
        drop_m = clr ? 1 : ((drop_m == CMAX) ? CMAX : drop_m + 1);
      end else if (clr) begin
        ovf_m  = 1'b0;
        drop_m = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("valid_out", 32'(valid_out), 32'(exp_q.size() != 0));
    chk("out",       32'(out),       (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    chk("level",     32'(level),     32'(exp_q.size()));
    chk("ovf",       32'(ovf),       32'(ovf_m));
    chk("drop_cnt",  32'(drop_cnt),  32'(drop_m));
  endtask

  task automatic idle(input logic rd_en);
    cycle(1'b0, 1'b0, '0, rd_en, 1'b0);
  endtask

  initial begin
    rst = 1'b1; valid_inp = 1'b0; dinp = '0; ready_out = 1'b0; ovf_clr = 1'b0;
    exp_q.delete(); ovf_m = 1'b0; drop_m = 0;

    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 9'h055, 1'b1, 1'b0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_out", 32'(out), 32'd0);

    // Write 3,5,7 with ready high, then a short stall pattern.
    tbl[0] = '{1'b1, 9'h003, 1'b1, 9'h003, 1'b1, 5'd1};
    tbl[1] = '{1'b1, 9'h005, 1'b1, 9'h005, 1'b1, 5'd1};
    tbl[2] = '{1'b1, 9'h007, 1'b1, 9'h007, 1'b1, 5'd1};
    tbl[3] = '{1'b0, 9'h000, 1'b1, 9'h000, 1'b0, 5'd0};
    tbl[4] = '{1'b1, 9'h009, 1'b0, 9'h009, 1'b1, 5'd1};
    tbl[5] = '{1'b1, 9'h1AB, 1'b0, 9'h009, 1'b1, 5'd2};
    tbl[6] = '{1'b0, 9'h000, 1'b1, 9'h1AB, 1'b1, 5'd1};
    tbl[7] = '{1'b0, 9'h000, 1'b0, 9'h1AB, 1'b1, 5'd1};
    tbl[8] = '{1'b0, 9'h000, 1'b1, 9'h000, 1'b0, 5'd0};
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      chk("tbl_out",   32'(out),       32'(tbl[i].e_out));
      chk("tbl_valid", 32'(valid_out), 32'(tbl[i].e_valid));
      chk("tbl_level", 32'(level),     32'(tbl[i].e_level));
      chk("tbl_ovf",   32'(ovf),       32'd0);
    end

    // Fill to DEPTH, drop one word, then drain in order.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b0, 1'b1, DW'(i), 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'(DEPTH));
    cycle(1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0);
    chk("drop_ovf", 32'(ovf), 32'd1);
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_head", 32'(out), 32'(i));
      idle(1'b1);
    end
    chk("drain_empty", 32'(valid_out), 32'd0);

    // ovf_clr without a drop clears both.
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_cnt", 32'(drop_cnt), 32'd0);

    // Full FIFO streaming with simultaneous read/write across pointer wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, DW'(9'h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, DW'(9'h120 + i), 1'b1, 1'b0);
      chk("stream_level", 32'(level), 32'(DEPTH));
      chk("stream_drop", 32'(drop_cnt), 32'd0);
    end
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // Toggling ready with continuous input until drops accumulate.
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, DW'(i + 1), (i % 2) == 0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, DW'(9'h0F0 + i), 1'b0, 1'b0);
    chk("sat_cnt", 32'(drop_cnt), 32'(CMAX));

    // ovf_clr coincident with a drop.
    cycle(1'b0, 1'b1, 9'h0EE, 1'b0, 1'b1);
    chk("clr_drop_ovf", 32'(ovf), 32'd1);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);

    // Reset mid-read with nine words stored.
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, DW'(9'h030 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("pre_rst_level", 32'(level), 32'd9);
    cycle(1'b1, 1'b1, 9'h077, 1'b1, 1'b0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    cycle(1'b0, 1'b1, 9'h0AA, 1'b0, 1'b0);
    chk("post_rst_out", 32'(out), 32'h0AA);
    idle(1'b1);

    // Randomized traffic with varying read pressure.
    for (int blk = 0; blk < 30; blk++) begin
      int rd_pct;
      rd_pct = $urandom_range(10, 95);
      for (int i = 0; i < 100; i++) begin
        cycle($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < 70,
              DW'($urandom),
              $urandom_range(0, 99) < rd_pct,
              $urandom_range(0, 39) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_stream_fifo.md
Name: sum_stream_fifo

Overview:
- Downstream stage of the two-input adder top: consumes its valid-only sum stream (out / valid_out, DATA_W+1 bits, no backpressure).
- Re-presents the stream through a valid/ready interface so later stages can stall.
- Single-clock synchronous FIFO with first-word-fall-through output, fill level, sticky overflow flag and a saturating drop counter.
- Runs in the clk domain produced by top (clk_out).

Parameters:
- DATA_W, 8, operand width of the upstream adder; payload width is DATA_W+1.
- DEPTH, 16, FIFO depth in words; power of two, >= 2.
- CNT_W, 16, width of drop counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- dinp  input  DATA_W+1  sum word from upstream
- valid_inp  input  1  dinp valid; no ready, so upstream never stalls
- out  output  DATA_W+1  head-of-FIFO word; 0 when valid_out=0
- valid_out  output  1  FIFO not empty
- ready_out  input  1  downstream accepts; transfer when valid_out && ready_out
- level  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH
- ovf  output  1  sticky overflow flag
- ovf_clr  input  1  clears ovf and drop_cnt
- drop_cnt  output  CNT_W  count of dropped input words, saturating

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=rd_ptr=0, level=0, valid_out=0, out=0, ovf=0, drop_cnt=0. Memory contents are not reset. Reset takes priority over all other inputs, including mid-burst; all stored words are discarded.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit:
  - empty = ptrs equal.
  - full = low bits equal and wrap bits differ.
  - Pointers wrap naturally from DEPTH-1 to 0.
- Write: valid_inp=1 and (not full, or a read occurs in the same cycle) -> mem[wr_ptr]<=dinp, wr_ptr+1.
- Read: valid_out && ready_out -> rd_ptr+1.
- level updates by +1 on write only, -1 on read only, and is unchanged on both or neither. It is registered and reflects the state after the edge.
- Latency is 1 cycle (FWFT): a word written at edge N is on out with valid_out=1 after edge N when the FIFO was empty. There is no combinational dinp->out bypass.
- out = mem[rd_ptr] when valid_out, else 0. out and valid_out are stable while valid_out && !ready_out.
- Full + valid_inp + read in the same cycle: the write is accepted, level stays DEPTH, no overflow.
- Full + valid_inp + no read: the word is dropped, memory and pointers are unchanged, ovf<=1, and drop_cnt increments, saturating at 2^CNT_W-1.
- Empty + ready_out: no read, rd_ptr unchanged.
- Empty + valid_inp + ready_out: the write is accepted; the read does not happen this cycle.
- ovf_clr=1: ovf<=0 and drop_cnt<=0. If a drop occurs in the same cycle, the drop wins: ovf<=1, drop_cnt<=1.
- Ordering is strict FIFO; no word is duplicated or reordered.

Test Plan:
- Reset release, DATA_W=8, DEPTH=16. Write 3, 5, 7 on consecutive cycles with ready_out=1 -> out shows 3, 5, 7 starting the cycle after the first write; level never exceeds 1; ovf=0.
- ready_out=0, write 0x001..0x010 (16 words) -> level=16. Write a 17th word 0x1FF -> dropped, ovf=1, drop_cnt=1. Then ready_out=1 -> reads 0x001..0x010 in order, 0x1FF never appears, valid_out=0 after the 16th read.
- Full FIFO with continuous valid_inp and ready_out=1 for 40 cycles -> level stays 16, drop_cnt stays 0, output sequence is exact input order across pointer wrap.
- ready_out toggling 1-0-1-0 while valid_inp=1 every cycle (incrementing data) -> out stable during stalls, no loss until full, then drop_cnt counts each dropped cycle.
- Overflow then ovf_clr pulse with no drop -> ovf=0, drop_cnt=0. ovf_clr coincident with a drop -> ovf=1, drop_cnt=1.
- rst asserted with level=9 mid-read -> next cycle level=0, valid_out=0, out=0. Write 0x0AA -> appears on out one cycle later.
